// File: rtl/pacman_video_pkg.sv
// Shared video-side definitions: PS/2 scan codes, move directions, motion FSM states.
// Used by player_motion_ctrl and frame_tick_gen.
package pacman_video_pkg;

   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;

   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_STOP  = 8'h29;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_COMMIT = 2'd2
   } motion_state_t;

   // Unrecognised codes keep the current direction so movement is sticky.
   function automatic dir_t decode_key(input logic [7:0] code, input dir_t cur);
      case (code)
         KEY_UP:    return DIR_UP;
         KEY_DOWN:  return DIR_DOWN;
         KEY_LEFT:  return DIR_LEFT;
         KEY_RIGHT: return DIR_RIGHT;
         KEY_STOP:  return DIR_NONE;
         default:   return cur;
      endcase
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vertical-sync falling-edge detector plus frame divider.
// frame_tick pulses one cycle after the edge is seen; due marks the tick that completes a frame group.
module frame_tick_gen
   import pacman_video_pkg::*;
#(
   parameter int FRAME_DIV = 2
) (
   input  logic iVGA_CLK,
   input  logic iRST_n,
   input  logic iVS,
   output logic frame_tick,
   output logic due
);

   localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

   logic          vs_q;
   logic          fall;
   logic [CW-1:0] frame_cnt;

   assign fall = vs_q & ~iVS;
   assign due  = (frame_cnt == CNT_LAST);

   always_ff @(posedge iVGA_CLK) begin
      if (!iRST_n) begin
         vs_q       <= 1'b1;
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         vs_q       <= iVS;
         frame_tick <= fall;
         if (frame_tick) begin
            frame_cnt <= due ? '0 : frame_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player sprite position controller: sticky PS/2 direction, one step per FRAME_DIV frames.
// Define PLAYER_WRAP_EN for horizontal tunnel wrap; otherwise x clamps like y.
//
// state     | meaning
// ST_IDLE   | waiting for a due frame tick
// ST_CALC   | direction snapshotted, next position being resolved
// ST_COMMIT | position registers just written, moved reflects the change
module player_motion_ctrl
   import pacman_video_pkg::*;
#(
   parameter int H_RES     = H_RES_DEF,
   parameter int V_RES     = V_RES_DEF,
   parameter int SPRITE_W  = 32,
   parameter int SPRITE_H  = 32,
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 2,
   parameter int START_X   = 304,
   parameter int START_Y   = 224
) (
   input  logic        iVGA_CLK,
   input  logic        iRST_n,
   input  logic        iVS,
   input  logic [7:0]  ps2_key_data_in,
   output logic [31:0] player0_x,
   output logic [31:0] player0_y,
   output logic        frame_tick,
   output logic        moved
);

   localparam logic signed [10:0] STEP_S  = 11'(STEP);
   localparam logic signed [10:0] X_MAX_S = 11'(H_RES - SPRITE_W);
   localparam logic signed [10:0] Y_MAX_S = 11'(V_RES - SPRITE_H);
   localparam logic [9:0]         X_MAX   = 10'(H_RES - SPRITE_W);
   localparam logic [8:0]         Y_MAX   = 9'(V_RES - SPRITE_H);

   logic [9:0]        x_q, nx;
   logic [8:0]        y_q, ny;
   logic signed [10:0] tmp;
   dir_t              dir, snap_dir;
   motion_state_t     state;
   logic              due;

   frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
      .iVGA_CLK   (iVGA_CLK),
      .iRST_n     (iRST_n),
      .iVS        (iVS),
      .frame_tick (frame_tick),
      .due        (due)
   );

   assign player0_x = {22'd0, x_q};
   assign player0_y = {23'd0, y_q};

   // Bounds are tested on the widened signed sum so underflow/overflow is never truncated away.
   always_comb begin
      nx  = x_q;
      ny  = y_q;
      tmp = '0;
      case (snap_dir)
         DIR_UP: begin
            tmp = $signed({2'b00, y_q}) - STEP_S;
            ny  = (tmp < 11'sd0) ? 9'd0 : tmp[8:0];
         end
         DIR_DOWN: begin
            tmp = $signed({2'b00, y_q}) + STEP_S;
            ny  = (tmp > Y_MAX_S) ? Y_MAX : tmp[8:0];
         end
         DIR_LEFT: begin
            tmp = $signed({1'b0, x_q}) - STEP_S;
`ifdef PLAYER_WRAP_EN
            nx  = (tmp < 11'sd0) ? X_MAX : tmp[9:0];
`else
            nx  = (tmp < 11'sd0) ? 10'd0 : tmp[9:0];
`endif
         end
         DIR_RIGHT: begin
            tmp = $signed({1'b0, x_q}) + STEP_S;
`ifdef PLAYER_WRAP_EN
            nx  = (tmp > X_MAX_S) ? 10'd0 : tmp[9:0];
`else
            nx  = (tmp > X_MAX_S) ? X_MAX : tmp[9:0];
`endif
         end
         default: begin
            nx = x_q;
            ny = y_q;
         end
      endcase
   end

   always_ff @(posedge iVGA_CLK) begin
      if (!iRST_n) begin
         x_q      <= 10'(START_X);
         y_q      <= 9'(START_Y);
         dir      <= DIR_NONE;
         snap_dir <= DIR_NONE;
         state    <= ST_IDLE;
         moved    <= 1'b0;
      end else begin
         dir   <= decode_key(ps2_key_data_in, dir);
         moved <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (frame_tick && due) begin
                  snap_dir <= dir;
                  state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               x_q   <= nx;
               y_q   <= ny;
               moved <= (nx != x_q) || (ny != y_q);
               state <= ST_COMMIT;
            end
            ST_COMMIT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule
